prim_unpacker_len: RTL and testbench

Variable-length unpacker: accepts InW-bit words, each tagged with a valid-lane count and a last flag, and emits them as a stream of OutW-bit chunks, least-significant lane first. It is the receive-side counterpart of the packing FIFO. It turns packed bus words, such as TL-UL read data or DMA beats, back into a narrow byte or halfword stream for serial peripherals. A held word that is fully drained can be replaced in the same cycle, so a continuous stream runs with no bubbles.

---
 rtl/prim_unpacker_len.sv | 78 +++++++
 tb/tb_prim_unpacker_len.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prim_unpacker_len.sv
// Variable-length unpacker: splits InW-bit words carrying a lane count into a
// stream of OutW-bit chunks, lane 0 first, with same-cycle reload on last pop.
module prim_unpacker_len #(
    parameter  int InW   = 32,
    parameter  int OutW  = 8,
    localparam int Ratio = InW / OutW,
    localparam int CntW  = $clog2(Ratio) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            wvalid_i,
    input  logic [InW-1:0]  wdata_i,
    input  logic [CntW-1:0] wlen_i,
    input  logic            wlast_i,
    output logic            wready_o,
    output logic            rvalid_o,
    output logic [OutW-1:0] rdata_o,
    output logic            rlast_o,
    input  logic            rready_i,
    output logic [CntW-1:0] depth_o
);
    localparam int PtrW = $clog2(Ratio);

    logic [InW-1:0]              r_data;
    logic [PtrW-1:0]             r_ptr;
    logic [CntW-1:0]             r_depth;
    logic                        r_last;
    logic                        r_clr;

    logic [Ratio-1:0][OutW-1:0]  w_lanes;
    logic [CntW-1:0]             w_len_eff;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_final;

    assign w_lanes   = r_data;
    assign w_final   = (r_depth == CntW'(1));
    assign w_len_eff = (wlen_i == '0 || wlen_i > CntW'(Ratio)) ? CntW'(Ratio) : wlen_i;

    // Reload is allowed while the last lane is leaving: rready_i feeds wready_o
    // combinationally so a continuous stream has no bubble between words.
    assign wready_o = !r_clr && (r_depth == '0 || (w_final && rready_i));
    assign rvalid_o = !r_clr && (r_depth != '0);
    assign rdata_o  = w_lanes[r_ptr];
    assign rlast_o  = rvalid_o && r_last && w_final;
    assign depth_o  = r_depth;

    assign w_push = wvalid_i && wready_o;
    assign w_pop  = rvalid_o && rready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data  <= '0;
            r_ptr   <= '0;
            r_depth <= '0;
            r_last  <= 1'b0;
            r_clr   <= 1'b1;
        end else begin
            r_clr <= clr_i;
            if (r_clr) begin
                r_data  <= '0;
                r_ptr   <= '0;
                r_depth <= '0;
                r_last  <= 1'b0;
            end else if (w_push) begin
                r_data  <= wdata_i;
                r_ptr   <= '0;
                r_depth <= w_len_eff;
                r_last  <= wlast_i;
            end else if (w_pop) begin
                r_depth <= r_depth - CntW'(1);
                // Park the pointer at 0 on the final pop so it stays below Ratio.
                r_ptr   <= w_final ? '0 : r_ptr + PtrW'(1);
            end
        end
    end
endmodule

// File: tb/tb_prim_unpacker_len.sv
// Directed bench for prim_unpacker_len (InW=32, OutW=8) with hand-computed chunks.
module tb_prim_unpacker_len;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        wvalid;
    logic [31:0] wdata;
    logic [2:0]  wlen;
    logic        wlast;
    logic        wready;
    logic        rvalid;
    logic [7:0]  rdata;
    logic        rlast;
    logic        rready;
    logic [2:0]  depth;

    int n_chk = 0;
    int n_err = 0;

    prim_unpacker_len #(.InW(32), .OutW(8)) u_dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clr_i    (clr),
        .wvalid_i (wvalid),
        .wdata_i  (wdata),
        .wlen_i   (wlen),
        .wlast_i  (wlast),
        .wready_o (wready),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .rlast_o  (rlast),
        .rready_i (rready),
        .depth_o  (depth)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the chunk currently presented, then let the clock edge pop it.
    task automatic exp_chunk(input string tag, input logic [7:0] d, input int dep, input logic lst);
        #1;
        chk({tag, ".vld"},   32'(rvalid), 32'd1);
        chk({tag, ".data"},  32'(rdata),  32'(d));
        chk({tag, ".depth"}, 32'(depth),  32'(dep));
        chk({tag, ".last"},  32'(rlast),  32'(lst));
        tick();
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] l, input logic lst);
        wvalid = 1'b1;
        wdata  = d;
        wlen   = l;
        wlast  = lst;
        tick();
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic chk_empty(input string tag);
        #1;
        chk({tag, ".vld"},   32'(rvalid), 32'd0);
        chk({tag, ".depth"}, 32'(depth),  32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        clr    = 1'b0;
        wvalid = 1'b0;
        wdata  = '0;
        wlen   = '0;
        wlast  = 1'b0;
        rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vld",   32'(rvalid), 32'd0);
        chk("rst.data",  32'(rdata),  32'd0);
        chk("rst.last",  32'(rlast),  32'd0);
        chk("rst.depth", 32'(depth),  32'd0);
        chk("rst.wrdy",  32'(wready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel.wrdy0", 32'(wready), 32'd0);
        tick();
        chk("rel.wrdy1", 32'(wready), 32'd1);

        // Basic unpack
        rready = 1'b1;
        wvalid = 1'b1;
        wdata  = 32'hDDCCBBAA;
        wlen   = 3'd4;
        #1;
        chk("basic.wrdy", 32'(wready), 32'd1);
        push(32'hDDCCBBAA, 3'd4, 1'b0);
        exp_chunk("basic0", 8'hAA, 4, 1'b0);
        exp_chunk("basic1", 8'hBB, 3, 1'b0);
        exp_chunk("basic2", 8'hCC, 2, 1'b0);
        exp_chunk("basic3", 8'hDD, 1, 1'b0);
        chk_empty("basic.end");

        // Back-to-back words, second word waits on the line
        wvalid = 1'b1;
        wdata  = 32'h44332211;
        wlen   = 3'd4;
        tick();
        wdata  = 32'h88776655;
        #1;
        chk("b2b.wait", 32'(wready), 32'd0);
        exp_chunk("b2b0", 8'h11, 4, 1'b0);
        exp_chunk("b2b1", 8'h22, 3, 1'b0);
        exp_chunk("b2b2", 8'h33, 2, 1'b0);
        #1;
        chk("b2b.reload", 32'(wready), 32'd1);
        exp_chunk("b2b3", 8'h44, 1, 1'b0);
        wvalid = 1'b0;
        exp_chunk("b2b4", 8'h55, 4, 1'b0);
        exp_chunk("b2b5", 8'h66, 3, 1'b0);
        exp_chunk("b2b6", 8'h77, 2, 1'b0);
        exp_chunk("b2b7", 8'h88, 1, 1'b0);
        chk_empty("b2b.end");

        // Short, last word
        push(32'h99887766, 3'd2, 1'b1);
        exp_chunk("short0", 8'h66, 2, 1'b0);
        exp_chunk("short1", 8'h77, 1, 1'b1);
        chk_empty("short.end");

        // Length clamp: 0 and 7 both mean 4 lanes
        push(32'h0D0C0B0A, 3'd0, 1'b0);
        exp_chunk("len0.0", 8'h0A, 4, 1'b0);
        exp_chunk("len0.1", 8'h0B, 3, 1'b0);
        exp_chunk("len0.2", 8'h0C, 2, 1'b0);
        exp_chunk("len0.3", 8'h0D, 1, 1'b0);
        chk_empty("len0.end");
        push(32'h14131211, 3'd7, 1'b1);
        exp_chunk("len7.0", 8'h11, 4, 1'b0);
        exp_chunk("len7.1", 8'h12, 3, 1'b0);
        exp_chunk("len7.2", 8'h13, 2, 1'b0);
        exp_chunk("len7.3", 8'h14, 1, 1'b1);
        chk_empty("len7.end");

        // Backpressure with BB pending
        push(32'hDDCCBBAA, 3'd4, 1'b0);
        exp_chunk("bp.aa", 8'hAA, 4, 1'b0);
        rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.vld",   32'(rvalid), 32'd1);
            chk("bp.data",  32'(rdata),  32'hBB);
            chk("bp.depth", 32'(depth),  32'd3);
            chk("bp.wrdy",  32'(wready), 32'd0);
            tick();
        end
        rready = 1'b1;
        exp_chunk("bp.bb", 8'hBB, 3, 1'b0);
        exp_chunk("bp.cc", 8'hCC, 2, 1'b0);
        rready = 1'b0;
        #1;
        chk("bp.last_wrdy", 32'(wready), 32'd0);
        rready = 1'b1;
        exp_chunk("bp.dd", 8'hDD, 1, 1'b0);
        chk_empty("bp.end");

        // Clear after first chunk pops
        push(32'hDDCCBBAA, 3'd4, 1'b0);
        exp_chunk("clr.aa", 8'hAA, 4, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        chk("clr.t1.vld",  32'(rvalid), 32'd0);
        chk("clr.t1.wrdy", 32'(wready), 32'd0);
        tick();
        chk("clr.t2.depth", 32'(depth),  32'd0);
        chk("clr.t2.wrdy",  32'(wready), 32'd1);
        chk("clr.t2.vld",   32'(rvalid), 32'd0);
        push(32'h04030201, 3'd2, 1'b0);
        exp_chunk("clr.new0", 8'h01, 2, 1'b0);
        exp_chunk("clr.new1", 8'h02, 1, 1'b0);
        chk_empty("clr.end");

        // Asynchronous reset mid-word
        push(32'hDDCCBBAA, 3'd4, 1'b1);
        exp_chunk("ar.aa", 8'hAA, 4, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar.vld",   32'(rvalid), 32'd0);
        chk("ar.data",  32'(rdata),  32'd0);
        chk("ar.depth", 32'(depth),  32'd0);
        chk("ar.last",  32'(rlast),  32'd0);
        chk("ar.wrdy",  32'(wready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("ar.rel.wrdy0", 32'(wready), 32'd0);
        tick();
        chk("ar.rel.wrdy1", 32'(wready), 32'd1);
        chk("ar.rel.vld",   32'(rvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
